// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack imem port, one-entry output buffer.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_INC   = 32'd4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        advance_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
`ifdef FETCH_PERF_CNT_EN
   output logic        valid_o,
   output logic [31:0] bubble_cnt_o,
   output logic [31:0] redirect_cnt_o
`else
   output logic        valid_o
`endif
);

   typedef enum logic [1:0] {FETCH, READY, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic [31:0] inst_buf, inst_buf_d;
   logic [31:0] buf_pc, buf_pc_d;
   logic        buf_valid, buf_valid_d;
   logic        accept;
   logic [31:0] pc_inc;

   assign pc_inc      = pc_q + PC_INC;
   assign imem_addr_o = req_addr_q;
   assign imem_req_o  = !rst_i && (state_q != READY);
   assign accept      = advance_i && valid_o && !redirect_i;

   always_comb begin
      inst_o  = 32'h0;
      pc_o    = 32'h0;
      valid_o = 1'b0;
      if (!rst_i) begin
         if (buf_valid) begin
            inst_o  = inst_buf;
            pc_o    = buf_pc;
            valid_o = 1'b1;
         end else if (state_q == FETCH && imem_ack_i) begin
            inst_o  = imem_rdata_i;
            pc_o    = req_addr_q + PC_INC;
            valid_o = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      inst_buf_d  = inst_buf;
      buf_pc_d    = buf_pc;
      buf_valid_d = buf_valid;
      unique case (state_q)
         FETCH: begin
            if (redirect_i) begin
               pc_d        = redirect_pc_i;
               buf_valid_d = 1'b0;
               if (imem_ack_i) req_addr_d = redirect_pc_i;
               else            state_d    = DRAIN;
            end else if (imem_ack_i) begin
               if (accept) begin
                  pc_d       = pc_inc;
                  req_addr_d = pc_inc;
               end else begin
                  inst_buf_d  = imem_rdata_i;
                  buf_pc_d    = req_addr_q + PC_INC;
                  buf_valid_d = 1'b1;
                  state_d     = READY;
               end
            end
         end
         READY: begin
            if (redirect_i) begin
               pc_d        = redirect_pc_i;
               req_addr_d  = redirect_pc_i;
               buf_valid_d = 1'b0;
               state_d     = FETCH;
            end else if (accept) begin
               pc_d        = pc_inc;
               req_addr_d  = pc_inc;
               buf_valid_d = 1'b0;
               state_d     = FETCH;
            end
         end
         DRAIN: begin
            if (redirect_i) pc_d = redirect_pc_i;
            // the stale response has arrived; restart at the newest target
            if (imem_ack_i) begin
               state_d    = FETCH;
               req_addr_d = redirect_i ? redirect_pc_i : pc_q;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         inst_buf   <= 32'h0;
         buf_pc     <= 32'h0;
         buf_valid  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         inst_buf   <= inst_buf_d;
         buf_pc     <= buf_pc_d;
         buf_valid  <= buf_valid_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_o   <= 32'h0;
         redirect_cnt_o <= 32'h0;
      end else begin
         if (!valid_o && !(&bubble_cnt_o))
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
         if (redirect_i && !(&redirect_cnt_o))
            redirect_cnt_o <= redirect_cnt_o + 32'd1;
      end
   end
`else
`endif

endmodule
